// File: rtl/product_accumulator_pkg.sv
// Shared types and helpers for the product accumulator.
// Holds the FSM state encoding and the count-width function.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUMULATE,
    OUTPUT
  } accumulator_state_t;

  // Enough bits to hold a count of 0..block_len.
  function automatic int count_width(input int block_len);
    return $clog2(block_len + 1);
  endfunction

endpackage

// File: rtl/accumulator_adder.sv
// Unsigned ACC_WIDTH adder with carry-out; clamps on carry when
// SATURATION_EN is defined. Ports: a_i, b_i in; sum_o, carry_o out.
module accumulator_adder #(
  parameter int ACC_WIDTH = 20
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 carry_o
);

  logic [ACC_WIDTH:0] full;

  always_comb begin
    full    = {1'b0, a_i} + {1'b0, b_i};
    carry_o = full[ACC_WIDTH];
`ifdef SATURATION_EN
    sum_o   = carry_o ? '1 : full[ACC_WIDTH-1:0];
`else
    sum_o   = full[ACC_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums BLOCK_LEN multiplier products and hands the block result on
// over valid/ready. Product in: product_i/product_valid_i/
// product_ready_o. Result out: accumulation_o/valid_o/ready_i, plus
// count_o and sticky overflow_o. clear_i aborts a block. Build
// macro SATURATION_EN clamps the sum instead of wrapping.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_LEN  = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic [2*DATA_WIDTH-1:0]           product_i,
  input  logic                              product_valid_i,
  output logic                              product_ready_o,
  output logic [ACC_WIDTH-1:0]              accumulation_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [count_width(BLOCK_LEN)-1:0] count_o,
  output logic                              overflow_o
);

  localparam int CW = count_width(BLOCK_LEN);

  accumulator_state_t   state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d, add_sum;
  logic [CW-1:0]        count_q, count_d, count_inc;
  logic                 ovf_q, ovf_d, add_carry;
  logic                 take, last, drain;

  // In IDLE sum_q is zero, so the same adder path loads the first
  // product; no separate load mux is needed.
  accumulator_adder #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_adder (
    .a_i     (sum_q),
    .b_i     (ACC_WIDTH'(product_i)),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  assign count_inc = count_q + CW'(1);
  assign last      = (count_inc == CW'(BLOCK_LEN));
  assign take      = product_valid_i && product_ready_o;
  assign drain     = (state_q == OUTPUT) && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, ACCUMULATE: begin
          if (take) state_d = last ? OUTPUT : ACCUMULATE;
        end
        OUTPUT: begin
          if (ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i || drain) begin
      sum_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (take) begin
      sum_d   = add_sum;
      count_d = count_inc;
      ovf_d   = ovf_q | add_carry;
    end
  end

  always_comb begin
    product_ready_o = (state_q != OUTPUT) && !clear_i && !rst_i;
    valid_o         = (state_q == OUTPUT);
    accumulation_o  = sum_q;
    count_o         = count_q;
    overflow_o      = ovf_q;
  end

endmodule
